// File: rtl/alu_pkg.sv
// Shared ALU op codes and the registered response layout for the ALU arbiter.
package alu_pkg;
  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 4'b0000;
  localparam alu_op_t ALU_SUB   = 4'b0001;
  localparam alu_op_t ALU_SLL   = 4'b0010;
  localparam alu_op_t ALU_SLT   = 4'b0011;
  localparam alu_op_t ALU_SLTU  = 4'b0100;
  localparam alu_op_t ALU_XOR   = 4'b0101;
  localparam alu_op_t ALU_SRL   = 4'b0110;
  localparam alu_op_t ALU_SRA   = 4'b0111;
  localparam alu_op_t ALU_OR    = 4'b1000;
  localparam alu_op_t ALU_AND   = 4'b1001;
  localparam alu_op_t ALU_LUI   = 4'b1010;
  localparam alu_op_t ALU_AUIPC = 4'b1011;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        err;
  } alu_rsp_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational RV32I ALU. Unknown op codes produce a zero result.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        less_than,
  output logic        less_than_u
);
  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_LUI:   result = b;
      ALU_AUIPC: result = a + b;
      default:   result = '0;
    endcase
  end

  assign zero        = (result == '0);
  assign less_than   = $signed(a) < $signed(b);
  assign less_than_u = a < b;
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a one-entry tagged response register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                OP_W   = 4,
  parameter logic [OP_W-1:0]   MAX_OP = 4'b1011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_lt,
  output logic              rsp_ltu,
  output logic              rsp_err
);
  logic              rr_last;
  logic              slot_free;
  logic              win1;
  logic              take;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_lt, alu_ltu;
  logic              illegal;
  alu_rsp_t          nxt, rsp_q;

  assign slot_free = !rsp_valid | rsp_ready;

  // Port 1 wins when alone, or when both are valid and port 0 was served last.
  assign win1 = req1_valid & (!req0_valid | !rr_last);
  assign take = rst_n & slot_free & (req0_valid | req1_valid);

  assign req0_ready = take & !win1;
  assign req1_ready = take & win1;

  // Idle cycles steer port 0 into the ALU; the result is simply not captured.
  assign sel_op = win1 ? req1_op : req0_op;
  assign sel_a  = win1 ? req1_a  : req0_a;
  assign sel_b  = win1 ? req1_b  : req0_b;

  alu_arbiter_alu u_alu (
    .op          (sel_op),
    .a           (sel_a),
    .b           (sel_b),
    .result      (alu_result),
    .zero        (alu_zero),
    .less_than   (alu_lt),
    .less_than_u (alu_ltu)
  );

  assign illegal = sel_op > MAX_OP;

  always_comb begin
    nxt = '0;
    if (illegal) begin
      nxt.zero = 1'b1;
      nxt.err  = 1'b1;
    end else begin
      nxt.result = alu_result;
      nxt.zero   = alu_zero;
      nxt.lt     = alu_lt;
      nxt.ltu    = alu_ltu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= '0;
      rr_last   <= 1'b1;
    end else if (take) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win1;
      rsp_q     <= nxt;
      rr_last   <= win1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_result = rsp_q.result;
  assign rsp_zero   = rsp_q.zero;
  assign rsp_lt     = rsp_q.lt;
  assign rsp_ltu    = rsp_q.ltu;
  assign rsp_err    = rsp_q.err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized check of alu_arbiter against a cycle-level
// reference of the grant rules and the RV32I ALU arithmetic.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        rdy = 1'b1;
  logic        r0, r1, rsp_valid, rsp_id, rsp_zero, rsp_lt, rsp_ltu, rsp_err;
  logic [31:0] rsp_result;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  logic        m_valid, m_id, m_last, m_zero, m_lt, m_ltu, m_err;
  logic [31:0] m_res;
  logic        acc0, acc1;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rdy), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_lt(rsp_lt),
    .rsp_ltu(rsp_ltu), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_last = 1;
    m_res = 0; m_zero = 0; m_lt = 0; m_ltu = 0; m_err = 0;
  endtask

  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    m_err = 0;
    m_lt  = ($signed(a) < $signed(b));
    m_ltu = (a < b);
    case (op)
      0:  m_res = a + b;
      1:  m_res = a - b;
      2:  m_res = a * (32'd1 << sh);
      3:  m_res = ($signed(a) < $signed(b)) ? 1 : 0;
      4:  m_res = (a < b) ? 1 : 0;
      5:  m_res = a ^ b;
      6:  m_res = a / (32'd1 << sh);
      7:  m_res = a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      8:  m_res = a | b;
      9:  m_res = a & b;
      10: m_res = b;
      11: m_res = a + b;
      default: begin m_res = 0; m_err = 1; m_lt = 0; m_ltu = 0; end
    endcase
    m_zero = (m_res == 0);
  endtask

  // One clock: check at the negedge, advance the reference at the posedge.
  task automatic cycle();
    logic free;
    int   g;
    @(negedge clk);
    free = !m_valid || rdy;
    g = -1;
    if (v0 && v1) g = m_last ? 0 : 1;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    chk("req0_ready", {31'd0, r0}, {31'd0, free && g == 0});
    chk("req1_ready", {31'd0, r1}, {31'd0, free && g == 1});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_flags", {28'd0, rsp_zero, rsp_lt, rsp_ltu, rsp_err},
                       {28'd0, m_zero, m_lt, m_ltu, m_err});
    end
    @(posedge clk);
    acc0 = free && g == 0;
    acc1 = free && g == 1;
    if (g >= 0 && free) begin
      m_valid = 1; m_id = g[0]; m_last = g[0];
      if (g == 0) ref_alu(op0, a0, b0); else ref_alu(op1, a1, b1);
    end else if (rdy) m_valid = 0;
    #1;
  endtask

  initial begin
    int waits0, waits1;
    model_reset();
    acc0 = 0; acc1 = 0;
    // reset: outputs cleared, no ready even with a valid request
    v0 = 1; op0 = 0; a0 = 5; b0 = 3;
    #12;
    chk("rst_valid", {31'd0, rsp_valid}, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_ready0", {31'd0, r0}, 0);
    chk("rst_flags", {27'd0, rsp_id, rsp_zero, rsp_lt, rsp_ltu, rsp_err}, 0);
    v0 = 0;
    @(posedge clk); #1; rst_n = 1;

    // single ADD
    v0 = 1; op0 = 0; a0 = 5; b0 = 3;
    cycle(); chk("single_acc", {31'd0, acc0}, 1);
    v0 = 0;
    cycle(); chk("single_res", rsp_result, 32'h8);

    // contention: SUB 5-5 vs OR A|5, both held valid
    v0 = 1; op0 = 1; a0 = 5; b0 = 5;
    v1 = 1; op1 = 8; a1 = 32'hA; b1 = 32'h5;
    waits0 = 0; waits1 = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (!acc0) waits0++; else waits0 = 0;
      if (!acc1) waits1++; else waits1 = 0;
      chk("fair_wait", {31'd0, (waits0 > 1) || (waits1 > 1)}, 0);
    end
    v0 = 0; v1 = 0;
    cycle();

    // backpressure: SLL 1<<4 held while port 1 waits
    v0 = 1; op0 = 2; a0 = 1; b0 = 4; rdy = 1;
    cycle(); v0 = 0; rdy = 0;
    v1 = 1; op1 = 0; a1 = 7; b1 = 9;
    for (int i = 0; i < 3; i++) begin
      cycle(); chk("bp_hold", rsp_result, 32'h10);
    end
    rdy = 1;
    cycle(); chk("bp_release_acc", {31'd0, acc1}, 1);
    v1 = 0;

    // illegal op on port 1
    v1 = 1; op1 = 4'hF; a1 = 32'h1234; b1 = 1;
    cycle(); v1 = 0;
    cycle(); chk("illegal_err", {31'd0, rsp_err}, 1);

    // SRA with flags
    v0 = 1; op0 = 7; a0 = 32'h80000000; b0 = 4;
    cycle(); v0 = 0; rdy = 0;
    cycle(); chk("sra_res", rsp_result, 32'hF8000000);

    // async reset with a held response
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 0);
    model_reset();
    rst_n = 1; rdy = 1;
    v0 = 1; op0 = 5; a0 = 32'hFF; b0 = 32'h0F;
    v1 = 1; op1 = 9; a1 = 32'hFF; b1 = 32'hF0;
    cycle(); chk("arst_first", {30'd0, acc1, acc0}, 32'b01);
    v0 = 0; v1 = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(3) != 0);
      cycle();
      if (acc0 || !v0) begin
        v0 = $urandom_range(1);
        op0 = ($urandom_range(9) == 0) ? 4'(12 + $urandom_range(3)) : 4'($urandom_range(11));
        a0 = $urandom; b0 = ($urandom_range(3) == 0) ? a0 : $urandom;
      end
      if (acc1 || !v1) begin
        v1 = $urandom_range(1);
        op1 = ($urandom_range(9) == 0) ? 4'(12 + $urandom_range(3)) : 4'($urandom_range(11));
        a1 = $urandom; b1 = ($urandom_range(3) == 0) ? a1 : $urandom;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
